// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free divisor reload at period boundaries.
// Define CLK_DIV_ODD50_EN to add a negedge stage that gives 50% duty for odd divisors.
module clk_div_prog #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DEF_DIV = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             clkout,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] div_eff;
  logic             clk_p;
  logic             wrap;
  logic             accept;
  logic             apply;
  logic             bypass;

  always_comb begin
    bypass   = (cur_div == One);
    wrap     = (cnt == cur_div - One);
    accept   = div_load && !div_busy && (div_val != '0);
    apply    = en && wrap && div_busy;
    // The level for the first cycle of a new period must use the incoming divisor.
    div_eff  = apply ? pend : cur_div;
    cnt_next = wrap ? '0 : cnt + One;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      clk_p    <= 1'b0;
      tick     <= 1'b0;
      div_busy <= 1'b0;
      pend     <= '0;
      cur_div  <= DefDiv;
    end else begin
      tick <= en && wrap;
      if (en) begin
        cnt   <= cnt_next;
        clk_p <= (cnt_next >= (div_eff >> 1));
      end
      if (apply) begin
        cur_div  <= pend;
        div_busy <= 1'b0;
      end else if (accept) begin
        pend     <= div_val;
        div_busy <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic clk_n;

  // Half-cycle delayed copy of clk_p; ANDing trims half a cycle off the high phase.
  always_ff @(negedge clk) begin
    if (rst) begin
      clk_n <= 1'b0;
    end else if (en) begin
      clk_n <= clk_p;
    end
  end

  assign clkout = bypass     ? (clk & en) :
                  cur_div[0] ? (clk_p & clk_n) : clk_p;
`else
  assign clkout = bypass ? (clk & en) : clk_p;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by random stimulus,
// all compared against a period/position model of the divider.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_busy;
  logic [7:0] cur_div;
  logic       clkout;
  logic       tick;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current output period and divisor in effect.
  int   m_pos = 0;
  int   m_n = 4;
  int   m_pend = 0;
  logic m_busy = 1'b0;
  logic m_tick = 1'b0;
  logic m_valid = 1'b0;
`ifdef CLK_DIV_ODD50_EN
  logic m_cn = 1'b0;
`endif

  logic       r_r, r_e, r_l;
  logic [7:0] r_v;

  clk_div_prog #(.WIDTH(8), .DEF_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_busy (div_busy),
    .cur_div  (cur_div),
    .clkout   (clkout),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output high in the upper half of the period; bypass passes the clock through.
  function automatic logic exp_clk(input logic phase_high, input logic e);
    logic lvl;
    if (m_n == 1) return phase_high && e;
    lvl = (m_pos >= m_n / 2);
`ifdef CLK_DIV_ODD50_EN
    if (m_n % 2 == 1) lvl = lvl && m_cn;
`endif
    return lvl;
  endfunction

  task automatic step(input logic r, input logic e, input logic l, input logic [7:0] v);
    logic wrapped;
    rst = r; en = e; div_load = l; div_val = v;
    @(negedge clk);
`ifdef CLK_DIV_ODD50_EN
    if (r) m_cn = 1'b0;
    else if (e) m_cn = (m_pos >= m_n / 2);
`endif
    #1;
    if (m_valid) chk("clkout_lo", {31'd0, clkout}, {31'd0, exp_clk(1'b0, e)});
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_n = 4; m_busy = 1'b0; m_tick = 1'b0; m_valid = 1'b1;
    end else begin
      wrapped = e && (m_pos == m_n - 1);
      m_tick  = wrapped;
      if (e) m_pos = wrapped ? 0 : m_pos + 1;
      if (m_busy && wrapped) begin
        m_n = m_pend; m_pos = 0; m_busy = 1'b0;
      end else if (l && !m_busy && v != 8'd0) begin
        m_pend = int'(v); m_busy = 1'b1;
      end
    end
    #1;
    chk("cur_div", {24'd0, cur_div}, m_n);
    chk("div_busy", {31'd0, div_busy}, {31'd0, m_busy});
    chk("tick", {31'd0, tick}, {31'd0, m_tick});
    chk("clkout_hi", {31'd0, clkout}, {31'd0, exp_clk(1'b1, e)});
    #1;
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
    // Reset wins over en and div_load.
    step(1'b1, 1'b1, 1'b1, 8'd9);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    chk("reset_cur_div", {24'd0, cur_div}, 32'd4);
    chk("reset_clkout", {31'd0, clkout}, 32'd0);
    run(8, 1'b1);

    // Load 5 while cnt=1; a second load and a zero load are ignored.
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd5);
    chk("busy_after_load", {31'd0, div_busy}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'd7);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    chk("cur_div_5", {24'd0, cur_div}, 32'd5);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    chk("zero_load_ignored", {31'd0, div_busy}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);

    // Freeze at cnt=3 of a 5-cycle period, then resume.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      chk("hold_high", {31'd0, clkout}, 32'd1);
    end
    run(2, 1'b1);
    chk("resume_tick", {31'd0, tick}, 32'd1);

    // Bypass, then leave bypass with en low at load time.
    step(1'b0, 1'b1, 1'b1, 8'd1);
    run(6, 1'b1);
    chk("bypass_div", {24'd0, cur_div}, 32'd1);
    run(4, 1'b1);
    run(3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd6);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    chk("leave_bypass", {24'd0, cur_div}, 32'd6);

    // Reset mid-period with a load pending.
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd7);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd9);
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_cur_div", {24'd0, cur_div}, 32'd4);
    run(5, 1'b1);

    // Largest legal divisor.
    step(1'b0, 1'b1, 1'b1, 8'd255);
    run(6, 1'b1);
    chk("max_div", {24'd0, cur_div}, 32'd255);
    run(258, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd3);
    run(258, 1'b1);

    for (int i = 0; i < 400; i++) begin
      r_r = ($urandom_range(0, 59) == 0);
      r_e = ($urandom_range(0, 7) != 0);
      r_l = ($urandom_range(0, 5) == 0);
      r_v = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      step(r_r, r_e, r_l, r_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 24, giving the divisor and counter width in bits.
REQ-002 SHALL have parameter DEF_DIV, default 1000000, giving the divisor loaded at reset; legal range 1..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port div_val  input  WIDTH  requested divisor N.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe requesting div_val.
REQ-008 SHALL have port div_busy  output  1  high while a load is pending.
REQ-009 SHALL have port cur_div  output  WIDTH  divisor currently in effect.
REQ-010 SHALL have port clkout  output  1  divided clock.
REQ-011 SHALL have port tick  output  1  one-cycle pulse per output period.

Function
REQ-012 SHALL keep counter cnt, range 0..cur_div-1, advancing on each posedge clk with en=1 and wrapping from cur_div-1 to 0.
REQ-013 SHALL register clk_p on posedge: with en=1, clk_p takes (cnt_next >= cur_div>>1), so clk_p is low while cnt < floor(N/2) and high otherwise.
REQ-014 SHALL drive clkout=clk_p for N>=2 when the ODD50 feature is absent or N is even; N=4 gives 2 low/2 high, N=5 gives 2 low/3 high.
REQ-015 SHALL drive clkout=clk & en when cur_div=1 (bypass); clkout=0 in bypass while en=0.
REQ-016 SHALL register tick high for exactly the one cycle following each enabled wrap edge; with cur_div=1 and en=1, tick stays high continuously.
REQ-017 SHALL, with en=0, freeze cnt, clk_p and clk_n, hold clkout at its present level (except bypass) and hold tick at 0.
REQ-018 SHALL accept div_load only when div_busy=0 and div_val!=0: the cycle after acceptance, div_val is in a pending register and div_busy=1.
REQ-019 SHALL ignore div_load when div_busy=1 or div_val=0, with no state change.
REQ-020 SHALL apply the pending divisor at the next enabled wrap edge: cur_div updates, cnt becomes 0, div_busy falls in that same edge, and the output period never changes mid-period.
REQ-021 SHALL, with a pending load and cur_div=1, apply it on the next enabled edge.
REQ-022 SHALL compute every comparison at WIDTH bits without overflow; N=2^WIDTH-1 is legal.

Reset
REQ-023 SHALL, on posedge clk with rst=1, set cnt=0, clk_p=0, clk_n=0, tick=0, div_busy=0, discard any pending divisor, and set cur_div=DEF_DIV.
REQ-024 SHALL give rst priority over en and div_load in the same cycle.
REQ-025 SHALL, on rst asserted mid-period, drive clkout low from the following edge (bypass excepted) and restart counting at cnt=0 after release.

Configuration
REQ-026 SHALL implement the ODD50 feature when macro CLK_DIV_ODD50_EN is defined: negedge flop clk_n samples clk_p; reset clears it synchronously at a negedge with rst=1; for odd N>=3, clkout=clk_p & clk_n, giving a high time of exactly N/2 clk periods (50% duty).
REQ-027 SHALL, without CLK_DIV_ODD50_EN, omit clk_n entirely; clkout follows REQ-014 and duty is uneven for odd N.

Verification
REQ-028 SHALL pass test WIDTH=8, DEF_DIV=4, en=1 after reset -> clkout period 4 clk, 2 low/2 high, tick once per 4 cycles, cur_div=4.
REQ-029 SHALL pass test div_load with div_val=5 at cnt=1 -> div_busy=1 from next cycle; the current period completes at 4; div_busy=0 and cur_div=5 from the wrap; next period is 5 cycles (2 low/3 high without the macro, 2.5/2.5 with it).
REQ-030 SHALL pass test second div_load (div_val=7) while busy, and div_load with div_val=0 -> both ignored; cur_div ends 5.
REQ-031 SHALL pass test load div_val=1 -> after wrap, clkout equals clk and tick stays high; drop en -> clkout=0, tick=0.
REQ-032 SHALL pass test en low for 10 cycles at cnt=3 (N=5) -> clkout holds high, cnt holds 3, no tick; resume completes the remaining 2 cycles.
REQ-033 SHALL pass test rst for 1 cycle mid-period with load pending -> clkout=0, div_busy=0, cur_div=4, period restarts at cnt=0.
